// File: rtl/seq_mac_multiplier.sv
// seq_mac_multiplier
//
// Iterative shift-and-add multiplier with optional accumulate, intended as the
// MAC element of processing-element columns. A single adder row retires
// ROWS_PER_CYCLE partial-product rows of B per clock, so an operation takes
// K = B_BIT / ROWS_PER_CYCLE RUN cycles. Supports unsigned and two's-complement
// operands, and can add the product to the previous result held in acc.
//
// Ports:
//   clk          sole clock, rising edge
//   rst          synchronous, active-high reset
//   in_valid     operands and mode bits are valid
//   in_ready     block can accept an operation (high only in IDLE)
//   A            multiplicand, A_BIT wide
//   B            multiplier, B_BIT wide
//   signed_mode  1: A and B are two's complement, 0: both unsigned
//   acc_en       1: M = acc + product, 0: M = product
//   out_valid    M holds a completed result
//   out_ready    consumer accepts M
//   M            result, OUT_BIT wide
module seq_mac_multiplier #(
    parameter int A_BIT          = 16,
    parameter int B_BIT          = 8,
    parameter int OUT_BIT        = 32,
    parameter int ROWS_PER_CYCLE = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [A_BIT-1:0]   A,
    input  logic [B_BIT-1:0]   B,
    input  logic               signed_mode,
    input  logic               acc_en,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_BIT-1:0] M
);

    // Derived latency; the guard keeps elaboration alive long enough for the
    // parameter checks below to report a bad ROWS_PER_CYCLE.
    localparam int K  = (ROWS_PER_CYCLE > 0) ? (B_BIT / ROWS_PER_CYCLE) : 1;
    localparam int CW = (K > 1) ? $clog2(K) : 1;
    localparam int BW = (B_BIT > 1) ? $clog2(B_BIT) : 1;

    if (B_BIT < 2) begin : g_err_bbit
        $error("seq_mac_multiplier: B_BIT must be at least 2");
    end
    if (OUT_BIT < A_BIT + B_BIT) begin : g_err_outbit
        $error("seq_mac_multiplier: OUT_BIT must be at least A_BIT+B_BIT");
    end
    if (ROWS_PER_CYCLE < 1 || (B_BIT % ROWS_PER_CYCLE) != 0) begin : g_err_rows
        $error("seq_mac_multiplier: ROWS_PER_CYCLE must divide B_BIT");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [A_BIT-1:0]   a_reg;
    logic [B_BIT-1:0]   b_reg;
    logic               sm_reg;
    logic               ae_reg;
    logic [OUT_BIT-1:0] psum;
    logic [OUT_BIT-1:0] acc;
    logic [CW-1:0]      cnt;

    logic [OUT_BIT-1:0] a_ext;
    logic [OUT_BIT-1:0] psum_next;
    logic [OUT_BIT-1:0] result;
    logic               last;

    // The adder row: fold this cycle's ROWS_PER_CYCLE rows into the partial
    // sum. In signed mode the MSB row of B carries weight -2^(B_BIT-1), so it
    // is subtracted; sign-extending A makes every row exact in OUT_BIT bits.
    always_comb begin
        int            row;
        logic [BW-1:0] row_idx;
        a_ext     = sm_reg ? {{(OUT_BIT-A_BIT){a_reg[A_BIT-1]}}, a_reg}
                           : {{(OUT_BIT-A_BIT){1'b0}}, a_reg};
        psum_next = psum;
        for (int r = 0; r < ROWS_PER_CYCLE; r++) begin
            row     = int'(cnt) * ROWS_PER_CYCLE + r;
            row_idx = row[BW-1:0];
            if (row < B_BIT && b_reg[row_idx]) begin
                if (sm_reg && row == B_BIT - 1) begin
                    psum_next = psum_next - (a_ext << row);
                end else begin
                    psum_next = psum_next + (a_ext << row);
                end
            end
        end
        last   = (cnt == CW'(K - 1));
        result = (ae_reg ? acc : '0) + psum_next;
    end

    // Control FSM with registered handshake outputs. in_ready depends only on
    // state, so there is no combinational path from in_valid or out_ready.
    // acc is written on every completion, which is why acc_en=0 restarts the
    // accumulation chain; an aborted operation never reaches that write.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            sm_reg    <= 1'b0;
            ae_reg    <= 1'b0;
            psum      <= '0;
            cnt       <= '0;
            acc       <= '0;
            M         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg    <= A;
                        b_reg    <= B;
                        sm_reg   <= signed_mode;
                        ae_reg   <= acc_en;
                        psum     <= '0;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    psum <= psum_next;
                    cnt  <= cnt + 1'b1;
                    if (last) begin
                        M         <= result;
                        acc       <= result;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mac_multiplier.sv
// tb_seq_mac_multiplier
//
// Scoreboard bench for seq_mac_multiplier. One default-parameter instance is
// exercised for latency, corners, accumulation, backpressure and reset abort;
// four 8x8->16 instances sweep ROWS_PER_CYCLE over 1, 2, 4 and 8.
module tb_seq_mac_multiplier;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [7:0]  b;
    logic        signed_mode;
    logic        acc_en;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] m;

    logic        sw_in_valid  [4];
    logic        sw_in_ready  [4];
    logic [7:0]  sw_a         [4];
    logic [7:0]  sw_b         [4];
    logic        sw_sm        [4];
    logic        sw_ae        [4];
    logic        sw_out_valid [4];
    logic        sw_out_ready [4];
    logic [15:0] sw_m         [4];

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q [$];
    logic [15:0] sw_q  [$];
    logic [31:0] model_acc;

    always #5 clk = ~clk;

    seq_mac_multiplier #(
        .A_BIT(16), .B_BIT(8), .OUT_BIT(32), .ROWS_PER_CYCLE(1)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(a), .B(b), .signed_mode(signed_mode), .acc_en(acc_en),
        .out_valid(out_valid), .out_ready(out_ready), .M(m)
    );

    for (genvar g = 0; g < 4; g++) begin : g_sweep
        seq_mac_multiplier #(
            .A_BIT(8), .B_BIT(8), .OUT_BIT(16), .ROWS_PER_CYCLE(1 << g)
        ) u_sweep (
            .clk(clk), .rst(rst), .in_valid(sw_in_valid[g]),
            .in_ready(sw_in_ready[g]), .A(sw_a[g]), .B(sw_b[g]),
            .signed_mode(sw_sm[g]), .acc_en(sw_ae[g]),
            .out_valid(sw_out_valid[g]), .out_ready(sw_out_ready[g]),
            .M(sw_m[g])
        );
    end

    // Reference product for the 16x8->32 instance, with optional accumulate.
    function automatic logic [31:0] ref_mac(input logic [15:0] fa, input logic [7:0] fb,
                                            input logic fsm, input logic fae,
                                            input logic [31:0] facc);
        longint pa;
        longint pb;
        logic [31:0] prod;
        pa   = fsm ? longint'($signed(fa)) : longint'(fa);
        pb   = fsm ? longint'($signed(fb)) : longint'(fb);
        prod = 32'(pa * pb);
        return fae ? facc + prod : prod;
    endfunction

    // Reference product for the 8x8->16 sweep instances.
    function automatic logic [15:0] ref_mul8(input logic [7:0] fa, input logic [7:0] fb,
                                             input logic fsm);
        longint pa;
        longint pb;
        pa = fsm ? longint'($signed(fa)) : longint'(fa);
        pb = fsm ? longint'($signed(fb)) : longint'(fb);
        return 16'(pa * pb);
    endfunction

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one operation and hold in_valid for exactly one accepting edge.
    task automatic drive_op(input logic [15:0] ta, input logic [7:0] tb_v,
                            input logic tsm, input logic tae, input logic [31:0] texp);
        int guard;
        guard = 0;
        while (!in_ready && guard < 50) begin
            tick();
            guard++;
        end
        a           = ta;
        b           = tb_v;
        signed_mode = tsm;
        acc_en      = tae;
        in_valid    = 1'b1;
        tick();
        in_valid    = 1'b0;
        exp_q.push_back(texp);
    endtask

    // Count edges from acceptance until out_valid, bounded.
    task automatic wait_done(output int cyc, output bit to);
        cyc = 0;
        to  = 1'b0;
        while (!out_valid) begin
            if (cyc >= 40) begin
                to = 1'b1;
                break;
            end
            tick();
            cyc++;
        end
    endtask

    // Wait for the result, capture it with its scoreboard entry, then handshake.
    task automatic collect(output int lat, output bit to,
                           output logic [31:0] got, output logic [31:0] expv);
        wait_done(lat, to);
        got  = m;
        expv = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_handshake: in_ready=%b out_valid=%b expected 1/0",
                     in_ready, out_valid);
        end
        checks++;
        if (m !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_m: got %h expected 00000000", m);
        end
        model_acc = 32'h0;
    endtask

    task automatic test_unsigned_max();
        int lat; bit to; logic [31:0] got; logic [31:0] expv;
        drive_op(16'hFFFF, 8'hFF, 1'b0, 1'b0, 32'h00FEFF01);
        model_acc = 32'h00FEFF01;
        collect(lat, to, got, expv);
        checks++;
        if (to || lat != 8) begin
            errors++;
            $display("[TB] FAIL umax_latency: got %0d (timeout=%0b) expected 8", lat, to);
        end
        checks++;
        if (got !== expv) begin
            errors++;
            $display("[TB] FAIL umax_m: got %h expected %h", got, expv);
        end
    endtask

    task automatic test_signed_corners();
        int lat; bit to; logic [31:0] got; logic [31:0] expv;
        drive_op(16'hFFFF, 8'h80, 1'b1, 1'b0, 32'h00000080);
        collect(lat, to, got, expv);
        checks++;
        if (to || got !== expv) begin
            errors++;
            $display("[TB] FAIL signed_m1_x_m128: got %h expected %h", got, expv);
        end
        drive_op(16'h8000, 8'h7F, 1'b1, 1'b0, 32'hFFC08000);
        collect(lat, to, got, expv);
        checks++;
        if (to || got !== expv) begin
            errors++;
            $display("[TB] FAIL signed_min_x_127: got %h expected %h", got, expv);
        end
        model_acc = 32'hFFC08000;
    endtask

    task automatic test_accumulate();
        int lat; bit to; logic [31:0] got; logic [31:0] expv;
        drive_op(16'd3, 8'd5, 1'b0, 1'b0, 32'd15);
        collect(lat, to, got, expv);
        checks++;
        if (to || got !== expv) begin
            errors++;
            $display("[TB] FAIL acc_start: got %h expected %h", got, expv);
        end
        drive_op(16'd2, 8'd7, 1'b0, 1'b1, 32'd29);
        collect(lat, to, got, expv);
        checks++;
        if (to || got !== expv) begin
            errors++;
            $display("[TB] FAIL acc_add: got %h expected %h", got, expv);
        end
        drive_op(16'd1, 8'd1, 1'b0, 1'b0, 32'd1);
        collect(lat, to, got, expv);
        checks++;
        if (to || got !== expv) begin
            errors++;
            $display("[TB] FAIL acc_restart: got %h expected %h", got, expv);
        end
        model_acc = 32'd1;
    endtask

    task automatic test_backpressure();
        int lat; bit to; logic [31:0] got; logic [31:0] expv;
        drive_op(16'd9, 8'd11, 1'b0, 1'b0, 32'd99);
        wait_done(lat, to);
        expv = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
        checks++;
        if (to || m !== expv) begin
            errors++;
            $display("[TB] FAIL bp_result: got %h expected %h", m, expv);
        end
        for (int i = 0; i < 5; i++) begin
            in_valid    = 1'b1;
            a           = 16'($urandom);
            b           = 8'($urandom);
            signed_mode = i[0];
            acc_en      = ~i[0];
            tick();
            checks++;
            if (m !== expv || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL bp_hold[%0d]: m=%h out_valid=%b in_ready=%b expected %h/1/0",
                         i, m, out_valid, in_ready, expv);
            end
        end
        a           = 16'd6;
        b           = 8'd7;
        signed_mode = 1'b0;
        acc_en      = 1'b0;
        out_ready   = 1'b1;
        tick();
        out_ready   = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_release: out_valid=%b in_ready=%b expected 0/1",
                     out_valid, in_ready);
        end
        tick();
        in_valid = 1'b0;
        exp_q.push_back(32'd42);
        model_acc = 32'd42;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_accept_next: in_ready=%b expected 0", in_ready);
        end
        collect(lat, to, got, expv);
        checks++;
        if (to || lat != 8 || got !== expv) begin
            errors++;
            $display("[TB] FAIL bp_next_op: got %h lat %0d expected %h lat 8", got, lat, expv);
        end
    endtask

    task automatic test_reset_mid_run();
        int lat; bit to; logic [31:0] got; logic [31:0] expv;
        drive_op(16'd10, 8'd10, 1'b0, 1'b0, 32'd100);
        collect(lat, to, got, expv);
        checks++;
        if (to || got !== expv) begin
            errors++;
            $display("[TB] FAIL rst_prep: got %h expected %h", got, expv);
        end
        drive_op(16'd5, 8'd5, 1'b0, 1'b1, 32'd125);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        void'(exp_q.pop_back());
        model_acc = 32'd0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || m !== 32'h0) begin
            errors++;
            $display("[TB] FAIL rst_abort: in_ready=%b out_valid=%b m=%h expected 1/0/00000000",
                     in_ready, out_valid, m);
        end
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rst_no_ghost: out_valid=%b expected 0", out_valid);
        end
        drive_op(16'd2, 8'd2, 1'b0, 1'b1, 32'd4);
        collect(lat, to, got, expv);
        model_acc = 32'd4;
        checks++;
        if (to || got !== expv) begin
            errors++;
            $display("[TB] FAIL rst_acc_cleared: got %h expected %h", got, expv);
        end
    endtask

    task automatic test_back_to_back();
        int lat; bit to; logic [31:0] expv; logic [31:0] e1; logic [31:0] e2;
        e1 = ref_mac(16'd4, 8'd4, 1'b0, 1'b0, model_acc);
        e2 = ref_mac(16'hFFFD, 8'h03, 1'b1, 1'b1, e1);
        out_ready = 1'b1;
        drive_op(16'd4, 8'd4, 1'b0, 1'b0, e1);
        wait_done(lat, to);
        expv = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
        checks++;
        if (to || lat != 8 || m !== expv) begin
            errors++;
            $display("[TB] FAIL b2b_first: got %h lat %0d expected %h lat 8", m, lat, expv);
        end
        a           = 16'hFFFD;
        b           = 8'h03;
        signed_mode = 1'b1;
        acc_en      = 1'b1;
        in_valid    = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_early_ready: out_valid=%b in_ready=%b expected 0/1",
                     out_valid, in_ready);
        end
        tick();
        in_valid = 1'b0;
        exp_q.push_back(e2);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_accept: in_ready=%b expected 0", in_ready);
        end
        wait_done(lat, to);
        expv = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
        checks++;
        if (to || lat != 8 || m !== expv) begin
            errors++;
            $display("[TB] FAIL b2b_second: got %h lat %0d expected %h lat 8", m, lat, expv);
        end
        tick();
        out_ready = 1'b0;
        model_acc = e2;
    endtask

    task automatic test_random();
        int lat; bit to; logic [31:0] got; logic [31:0] expv;
        logic [15:0] ra; logic [7:0] rb; logic rsm; logic rae; logic [31:0] e;
        for (int i = 0; i < 8; i++) begin
            ra  = 16'($urandom);
            rb  = 8'($urandom);
            rsm = 1'($urandom);
            rae = 1'($urandom);
            e   = ref_mac(ra, rb, rsm, rae, model_acc);
            model_acc = e;
            drive_op(ra, rb, rsm, rae, e);
            collect(lat, to, got, expv);
            checks++;
            if (to || lat != 8 || got !== expv) begin
                errors++;
                $display("[TB] FAIL random[%0d]: got %h lat %0d expected %h lat 8",
                         i, got, lat, expv);
            end
        end
    endtask

    task automatic test_sweep();
        int lat; int lat_exp; int guard; bit to;
        logic [7:0] sa; logic [7:0] sb; logic ssm; logic [15:0] expv;
        for (int k = 0; k < 4; k++) begin
            lat_exp = 8 / (1 << k);
            for (int i = 0; i < 6; i++) begin
                if (i == 0) begin
                    sa = 8'hFF; sb = 8'hFF; ssm = 1'b0;
                end else if (i == 1) begin
                    sa = 8'h80; sb = 8'h80; ssm = 1'b1;
                end else begin
                    sa = 8'($urandom); sb = 8'($urandom); ssm = i[0];
                end
                guard = 0;
                while (!sw_in_ready[k] && guard < 50) begin
                    tick();
                    guard++;
                end
                sw_a[k]        = sa;
                sw_b[k]        = sb;
                sw_sm[k]       = ssm;
                sw_ae[k]       = 1'b0;
                sw_in_valid[k] = 1'b1;
                tick();
                sw_in_valid[k] = 1'b0;
                sw_q.push_back(ref_mul8(sa, sb, ssm));
                lat = 0;
                to  = 1'b0;
                while (!sw_out_valid[k]) begin
                    if (lat >= 40) begin
                        to = 1'b1;
                        break;
                    end
                    tick();
                    lat++;
                end
                checks++;
                if (to || lat != lat_exp) begin
                    errors++;
                    $display("[TB] FAIL sweep_latency rpc=%0d op %0d: got %0d expected %0d",
                             1 << k, i, lat, lat_exp);
                end
                expv = (sw_q.size() > 0) ? sw_q.pop_front() : 16'hxxxx;
                checks++;
                if (sw_m[k] !== expv) begin
                    errors++;
                    $display("[TB] FAIL sweep_m rpc=%0d op %0d: got %h expected %h",
                             1 << k, i, sw_m[k], expv);
                end
                sw_out_ready[k] = 1'b1;
                tick();
                sw_out_ready[k] = 1'b0;
            end
        end
    endtask

    // Watchdog so a stuck handshake still ends the run.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst         = 1'b1;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        a           = '0;
        b           = '0;
        signed_mode = 1'b0;
        acc_en      = 1'b0;
        model_acc   = '0;
        for (int i = 0; i < 4; i++) begin
            sw_in_valid[i]  = 1'b0;
            sw_a[i]         = '0;
            sw_b[i]         = '0;
            sw_sm[i]        = 1'b0;
            sw_ae[i]        = 1'b0;
            sw_out_ready[i] = 1'b0;
        end
        test_reset();
        test_unsigned_max();
        test_signed_corners();
        test_accumulate();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        test_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_mac_multiplier.md
# seq_mac_multiplier

Iterative, parametrised successor to the combinational array multiplier in the arithmetic-operator library. Processes ROWS_PER_CYCLE partial-product rows of B per clock through a single adder row, which trades latency for area. Adds a two's-complement signed mode, an optional accumulate into a result register, and valid/ready handshakes on input and output. Intended for use as the MAC element of processing-element columns, where the full combinational array is too large.

## Interface
- A_BIT, 16: width of operand A.
- B_BIT, 8: width of operand B. Must be ≥2.
- OUT_BIT, 32: result width. Must be ≥ A_BIT+B_BIT.
- ROWS_PER_CYCLE, 1: B rows retired per RUN cycle. Must divide B_BIT.
- Illegal parameter combinations raise an elaboration-time $error.
- K is the derived latency, B_BIT/ROWS_PER_CYCLE.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands and mode bits are valid.
- in_ready  out  1  block can accept an operation.
- A  in  A_BIT  multiplicand.
- B  in  B_BIT  multiplier.
- signed_mode  in  1  1: A and B are two's complement; 0: both are unsigned.
- acc_en  in  1  1: M = acc + product; 0: M = product.
- out_valid  out  1  M holds a completed result.
- out_ready  in  1  consumer accepts M.
- M  out  OUT_BIT  result.

## Operation
- FSM states are IDLE, RUN and DONE. Reset state is IDLE.
- **IDLE**
  - in_ready=1.
  - On in_valid&in_ready: capture A, B, signed_mode and acc_en; clear the partial sum and row counter; go to RUN.
- **RUN**
  - in_ready=0.
  - Each cycle, add ROWS_PER_CYCLE rows (A & B[i]) << i into the partial sum, working from LSB to MSB of B. Increment the counter.
  - The edge that retires row B_BIT-1 also:
    - writes M;
    - writes acc := M;
    - moves the FSM to DONE.
- **DONE**
  - out_valid=1. M is held stable.
  - On out_valid&out_ready, go to IDLE.
  - in_valid is ignored in this state.
- **Arithmetic**
  - Unsigned mode: A and B are zero-extended to OUT_BIT.
  - Signed mode:
    - A is sign-extended to OUT_BIT.
    - Row B_BIT-1 is subtracted (it has weight -2^(B_BIT-1)) instead of added.
  - The product is exact in OUT_BIT bits. Upper bits are sign- or zero-extended per mode.
  - Accumulation is acc + product modulo 2^OUT_BIT. It wraps with no saturation and no overflow flag.
- acc is updated on every completion, whether acc_en is 0 or 1. acc_en=0 therefore starts a new accumulation chain.
- signed_mode and acc_en are sampled only at acceptance. Changes during RUN or DONE have no effect.

## Timing
- Values after a reset edge:
  - state=IDLE, in_ready=1, out_valid=0;
  - M=0, acc=0, partial sum and counter =0.
- Reset asserted in RUN or DONE aborts the operation. The result is discarded and acc is not updated by it.
- Latency: an operation accepted at edge t0 asserts out_valid after edge t0+K.
  - With default parameters, K=8.
  - With ROWS_PER_CYCLE=B_BIT, K=1.
- After the output handshake at edge t1, in_ready=1 from t1 onward. The next acceptance is at edge t1+1 at the earliest.
- Best-case throughput is one operation per K+2 cycles.
- out_ready may be high before out_valid. The handshake then completes on the first DONE cycle.
- in_ready is a function of state only. There is no combinational path from out_ready or in_valid to in_ready.
- M changes only on the edge that completes RUN, or on reset.

## Test plan
- Unsigned maximum, defaults: A=16'hFFFF, B=8'hFF, signed_mode=0, acc_en=0.
  - out_valid rises exactly 8 cycles after acceptance.
  - M=32'h00FEFF01.
- Signed corners:
  - A=16'hFFFF, B=8'h80 (-1×-128) → M=32'h00000080.
  - A=16'h8000, B=8'h7F → M=32'hFFC08000.
- Accumulate chain:
  - 3×5 with acc_en=0 → M=15.
  - Then 2×7 with acc_en=1 → M=29.
  - Then 1×1 with acc_en=0 → M=1.
- Backpressure:
  - Hold out_ready=0 for 5 cycles in DONE while toggling in_valid and operands.
  - M, out_valid=1 and in_ready=0 stay stable.
  - No new operation is accepted until the cycle after out_ready=1.
- Reset mid-RUN:
  - Assert rst 3 cycles after accepting 5×5 with acc_en=1, with acc previously 100.
  - Next cycle: IDLE, in_ready=1, out_valid=0, M=0.
  - A following 2×2 with acc_en=1 gives M=4.
- Parameter sweep: ROWS_PER_CYCLE ∈ {1,2,4,8} and A_BIT=B_BIT=8, OUT_BIT=16.
  - Compare random signed and unsigned operands against a reference model.
  - Latency must equal B_BIT/ROWS_PER_CYCLE; for example, ROWS_PER_CYCLE=2 gives 4 cycles.
